booth_mult_n: RTL and testbench
===============================

BOOTH_MULT_N -- requirements
Module: booth_mult_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication, sampled only in IDLE.
REQ-005 The block SHALL have port signo, input, 1 bit: operand mode, 1 = two's-complement signed, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have port multiplicando, input, WIDTH bits: the multiplicand, sampled with start.
REQ-007 The block SHALL have port multiplicador, input, WIDTH bits: the multiplier, sampled with start.
REQ-008 The block SHALL have port resultado, output, 2*WIDTH bits: the registered product of the last completed operation.
REQ-009 The block SHALL have port fin, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port ocupado, output, 1 bit: high while an operation is in progress.

Function
REQ-011 The block SHALL implement radix-2 Booth multiplication with a datapath / control-unit split inside the module: states IDLE and CALC only.
REQ-012 In IDLE with start=1 at a clock edge, the block SHALL load M = operands extended to WIDTH+1 bits (sign-extended if signo=1, zero-extended if signo=0), accumulator A=0, Q = extended multiplier, Q_-1=0, counter=WIDTH+1, and enter CALC.
REQ-013 Each CALC cycle SHALL examine {Q[0],Q_-1}: 10 -> A=A-M, 01 -> A=A+M, 00/11 -> A unchanged; then arithmetic-shift {A,Q,Q_-1} right one bit and decrement counter, all in the same edge.
REQ-014 A, M and Q SHALL each be WIDTH+1 bits; no overflow handling is needed because extended operands never equal the most negative (WIDTH+1)-bit value.
REQ-015 On the edge performing the final iteration (counter 1->0), the block SHALL load resultado with the low 2*WIDTH bits of the shifted {A,Q}, set fin=1, and return to IDLE.
REQ-016 Latency SHALL be exactly WIDTH+1 clocks: start sampled at edge k -> fin high and resultado valid in the cycle following edge k+WIDTH+1.
REQ-017 fin SHALL be high for exactly one cycle per completed operation.
REQ-018 resultado SHALL hold its value from completion until the next completion or reset; it SHALL NOT change during CALC.
REQ-019 ocupado SHALL be 1 in CALC and 0 in IDLE (registered, from the state).
REQ-020 start asserted while in CALC SHALL be ignored; operands and signo changing during CALC SHALL NOT affect the result.
REQ-021 start asserted in the cycle fin=1 SHALL be accepted (state is already IDLE), giving back-to-back operations with no idle gap.
REQ-022 The unsigned result SHALL equal multiplicando*multiplicador modulo 2^(2*WIDTH) (exact); the signed result SHALL be the exact two's-complement product, including -2^(WIDTH-1) * -2^(WIDTH-1).

Reset
REQ-023 When reset=1 at an edge, the block SHALL enter IDLE and clear resultado, fin, ocupado, A, Q, Q_-1, M and counter to 0.
REQ-024 reset SHALL take priority over start and over any CALC iteration; an operation aborted by reset SHALL NOT produce fin.
REQ-025 start sampled in the same edge as reset SHALL be ignored.

Verification
REQ-026 WIDTH=8, signo=1, multiplicando=8'hFD (-3), multiplicador=8'h05 -> after 9 clocks fin=1, resultado=16'hFFF1 (-15).
REQ-027 WIDTH=8, signo=0, 8'hFF * 8'hFF -> resultado=16'hFE01; same operands with signo=1 -> 16'h0001.
REQ-028 WIDTH=8, signo=1, 8'h80 * 8'h80 -> resultado=16'h4000; 8'h80 * 8'h7F -> 16'hC080.
REQ-029 WIDTH=3, signo=1, 3'b011 * 3'b100 (3 * -4) -> after 4 clocks resultado=6'h34 (-12), fin one cycle.
REQ-030 WIDTH=8: start 2*3; re-pulse start with 7*7 at cycle 3 -> ignored, resultado=16'h0006; start in fin cycle with 7*7 -> 16'h0031 exactly 9 clocks later.
REQ-031 WIDTH=8: start 5*5, assert reset at cycle 4 -> no fin ever, resultado=16'h0000, ocupado=0 next cycle; exhaustive random signed/unsigned compare vs reference model.

Source files
------------

// File: rtl/booth_mult_n.sv
// booth_mult_n: sequential radix-2 Booth multiplier.
//   Multiplies two WIDTH-bit operands, signed or unsigned. The
//   result is ready WIDTH+1 clocks after start is accepted.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   start          in   begin an operation (sampled in IDLE only)
//   signo          in   1 = two's-complement operands, 0 = unsigned
//   multiplicando  in   multiplicand [WIDTH-1:0]
//   multiplicador  in   multiplier   [WIDTH-1:0]
//   resultado      out  product of the last completed operation [2*WIDTH-1:0]
//   fin            out  one-cycle completion pulse
//   ocupado        out  high while an operation is in progress
//
// state | meaning
// IDLE  | waiting for start; resultado holds the last product
// CALC  | one Booth add/sub + arithmetic shift per clock, WIDTH+1 clocks
module booth_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signo,
  input  logic [WIDTH-1:0]   multiplicando,
  input  logic [WIDTH-1:0]   multiplicador,
  output logic [2*WIDTH-1:0] resultado,
  output logic               fin,
  output logic               ocupado
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               fin_q, fin_d;
  logic [WIDTH:0]     a_sum;

  // Booth recoding of the current multiplier bit pair
  always_comb begin
    a_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_q;
      2'b01:   a_sum = a_q + m_q;
      default: a_sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // One extra bit lets unsigned operands ride a signed datapath
          m_d     = signo ? {multiplicando[WIDTH-1], multiplicando}
                          : {1'b0, multiplicando};
          q_d     = signo ? {multiplicador[WIDTH-1], multiplicador}
                          : {1'b0, multiplicador};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        // Arithmetic right shift of {A, Q, Q_-1} after the add/sub
        a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d   = {a_sum[0], q_q[WIDTH:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Low 2*WIDTH bits of the shifted {A, Q}
          res_d   = {a_sum[WIDTH-1:0], q_q[WIDTH:1]};
          fin_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
    end
  end

  assign resultado = res_q;
  assign fin       = fin_q;
  assign ocupado   = (state_q == CALC);

endmodule

// File: tb/tb_booth_mult_n.sv
module tb_booth_mult_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, signo;
  logic [7:0]  mcand, mplier;
  logic [15:0] res;
  logic        fin, busy;

  logic        start3, signo3;
  logic [2:0]  mcand3, mplier3;
  logic [5:0]  res3;
  logic        fin3, busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mult_n #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .signo(signo),
    .multiplicando(mcand), .multiplicador(mplier),
    .resultado(res), .fin(fin), .ocupado(busy)
  );

  booth_mult_n #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .signo(signo3),
    .multiplicando(mcand3), .multiplicador(mplier3),
    .resultado(res3), .fin(fin3), .ocupado(busy3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic s, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; signo = s; mcand = a; mplier = b;
    step();
    start = 1'b0;
  endtask

  // Waits for fin after a start edge; optionally re-pulses start (with
  // scrambled operands) at cycle inj to prove CALC ignores it.
  task automatic wait_fin(input string tag, input logic [15:0] exp, input int inj);
    int n = 0;
    logic changed = 1'b0;
    logic [15:0] prev = res;
    while (!fin && n < 20) begin
      if (n == inj) begin
        start = 1'b1; signo = ~signo; mcand = 8'd7; mplier = 8'd7;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
      if (!fin && res !== prev) changed = 1'b1;
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'd9);
    check({tag, "_res"}, 64'(res), 64'(exp));
    check({tag, "_hold"}, 64'(changed), 64'd0);
  endtask

  initial begin
    logic [15:0] expv;
    logic        saw_fin;
    int          lat;
    reset = 1'b1; start = 1'b0; signo = 1'b0; mcand = '0; mplier = '0;
    start3 = 1'b0; signo3 = 1'b0; mcand3 = '0; mplier3 = '0;
    step(); step();
    reset = 1'b0;
    check("rst_res", 64'(res), 64'd0);
    check("rst_fin", 64'(fin), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // -3 * 5 signed
    start_op(1'b1, 8'hFD, 8'h05);
    check("busy_calc", 64'(busy), 64'd1);
    wait_fin("neg3x5", 16'hFFF1, -1);
    check("fin_idle_busy", 64'(busy), 64'd0);
    step();
    check("fin_pulse", 64'(fin), 64'd0);

    start_op(1'b0, 8'hFF, 8'hFF);
    wait_fin("ffxff_u", 16'hFE01, -1);
    start_op(1'b1, 8'hFF, 8'hFF);
    wait_fin("ffxff_s", 16'h0001, -1);
    start_op(1'b1, 8'h80, 8'h80);
    wait_fin("80x80_s", 16'h4000, -1);
    start_op(1'b1, 8'h80, 8'h7F);
    wait_fin("80x7f_s", 16'hC080, -1);

    // Restart ignored in CALC, then accepted in the fin cycle
    step();
    start_op(1'b0, 8'd2, 8'd3);
    wait_fin("2x3_ign", 16'h0006, 2);
    start_op(1'b0, 8'd7, 8'd7);
    check("b2b_fin_drop", 64'(fin), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_fin("7x7_b2b", 16'h0031, -1);

    // Reset aborts an operation mid-flight
    step();
    start_op(1'b0, 8'd5, 8'd5);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_res", 64'(res), 64'd0);
    saw_fin = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (fin) saw_fin = 1'b1;
    end
    check("abort_nofin", 64'(saw_fin), 64'd0);

    // Start coincident with reset is dropped
    reset = 1'b1; start = 1'b1; signo = 1'b0; mcand = 8'd9; mplier = 8'd9;
    step();
    reset = 1'b0; start = 1'b0;
    step();
    check("rst_start_busy", 64'(busy), 64'd0);

    // WIDTH=3: 3 * -4
    start3 = 1'b1; signo3 = 1'b1; mcand3 = 3'b011; mplier3 = 3'b100;
    step();
    start3 = 1'b0;
    lat = 0;
    while (!fin3 && lat < 20) begin
      step();
      lat++;
    end
    check("w3_lat", 64'(lat), 64'd4);
    check("w3_res", 64'(res3), 64'h34);
    step();
    check("w3_pulse", 64'(fin3), 64'd0);

    // Random signed/unsigned against a behavioural product
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a, b;
      logic       s;
      logic signed [15:0] sp;
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      if (s) begin
        sp = $signed(a) * $signed(b);
        expv = sp;
      end else begin
        expv = a * b;
      end
      start_op(s, a, b);
      wait_fin("rand", expv, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
